// File: rtl/intan_fifo_reader.sv
// intan_fifo_reader: on a start request, waits for the upstream intan FIFO to
// hold a frame, then reads WORD_NUM words as high/low byte pairs, presents
// each assembled word with a valid/ready handshake and pulses fd_read when
// the transfer completes or times out.
// Optional build macro INTAN_RX_STABLE_EN: when defined, each byte is only
// accepted after STABLE_CNT consecutive identical samples (the FIFO data may
// be unstable across clock domains); otherwise each byte read takes a single
// cycle and latches its first sample.
module intan_fifo_reader #(
  parameter int WORD_NUM   = 8,
  parameter int STABLE_CNT = 3,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fs_read,
  output logic        fd_read,
  input  logic        fifo_full,
  output logic [1:0]  fifo_rxen,
  input  logic [15:0] fifo_rxd,
  output logic [15:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int WW = (WORD_NUM > 1) ? $clog2(WORD_NUM) : 1;

  if (WORD_NUM < 1 || STABLE_CNT < 2 || TIMEOUT < 1) begin : g_param_check
    $error("intan_fifo_reader: illegal parameter value");
  end

  typedef enum logic [2:0] {IDLE, WAIT, RDH, RDL, SEND, DONE} state_t;

  state_t        state, state_n;
  logic [TW-1:0] tcnt;
  logic [WW-1:0] wcnt;
  logic [7:0]    hi_byte;
  logic [7:0]    byte_in;
  logic          byte_ok;
  logic          at_limit;
  logic          tout;
  logic          last_word;

  // Byte lane under test: high byte while in RDH, low byte otherwise
  always_comb begin
    byte_in = (state == RDH) ? fifo_rxd[15:8] : fifo_rxd[7:0];
  end

  // The TIMEOUT-th cycle spent in a guarded state is the last one allowed
  assign at_limit  = (tcnt == TW'(TIMEOUT - 1));
  assign last_word = (wcnt == WW'(WORD_NUM - 1));

`ifdef INTAN_RX_STABLE_EN
  localparam int MW = $clog2(STABLE_CNT + 1);

  logic [7:0]    samp_q;
  logic [MW-1:0] mcnt_q;
  logic [MW-1:0] mcnt_n;

  // Run length of identical samples; the first cycle in a state starts a new run
  always_comb begin
    mcnt_n = MW'(1);
    if (tcnt != '0 && byte_in == samp_q) mcnt_n = mcnt_q + MW'(1);
    byte_ok = (mcnt_n == MW'(STABLE_CNT));
  end

  // Sample register and match counter, only advanced while reading a byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_q <= '0;
      mcnt_q <= '0;
    end else if (state == RDH || state == RDL) begin
      samp_q <= byte_in;
      mcnt_q <= mcnt_n;
    end
  end
`else
  // Without the filter every byte read completes on its first cycle
  assign byte_ok = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_n    = state;
    tout       = 1'b0;
    fifo_rxen  = 2'b00;
    fd_read    = 1'b0;
    dout_valid = 1'b0;
    case (state)
      IDLE: begin
        if (fs_read) state_n = WAIT;
      end
      WAIT: begin
        if (fifo_full) begin
          state_n = RDH;
        end else if (at_limit) begin
          state_n = DONE;
          tout    = 1'b1;
        end
      end
      RDH: begin
        fifo_rxen = 2'b10;
        if (byte_ok) begin
          state_n = RDL;
        end else if (at_limit) begin
          state_n = DONE;
          tout    = 1'b1;
        end
      end
      RDL: begin
        fifo_rxen = 2'b01;
        if (byte_ok) begin
          state_n = SEND;
        end else if (at_limit) begin
          state_n = DONE;
          tout    = 1'b1;
        end
      end
      SEND: begin
        dout_valid = 1'b1;
        if (dout_ready) state_n = last_word ? DONE : RDH;
      end
      DONE: begin
        fd_read = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Per-state cycle counter (saturating), word counter, byte/word capture, error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt    <= '0;
      wcnt    <= '0;
      hi_byte <= '0;
      dout    <= '0;
      err     <= 1'b0;
    end else begin
      if (state_n != state)           tcnt <= '0;
      else if (tcnt != TW'(TIMEOUT))  tcnt <= tcnt + TW'(1);

      if (state == WAIT)                                  wcnt <= '0;
      else if (state == SEND && dout_ready && !last_word) wcnt <= wcnt + WW'(1);

      if (state == RDH && byte_ok) hi_byte <= byte_in;
      if (state == RDL && byte_ok) dout    <= {hi_byte, byte_in};

      if (state == IDLE && fs_read) err <= 1'b0;
      else if (tout)                err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_intan_fifo_reader.sv
// Testbench for intan_fifo_reader: directed and randomized transfers checked
// against a window-based byte acceptance model.
module tb_intan_fifo_reader;

  localparam int WORD_NUM   = 2;
  localparam int STABLE_CNT = 3;
  localparam int TIMEOUT    = 16;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        fs_read;
  logic        fd_read;
  logic        fifo_full;
  logic [1:0]  fifo_rxen;
  logic [15:0] fifo_rxd;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  intan_fifo_reader #(
    .WORD_NUM  (WORD_NUM),
    .STABLE_CNT(STABLE_CNT),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fs_read   (fs_read),
    .fd_read   (fd_read),
    .fifo_full (fifo_full),
    .fifo_rxen (fifo_rxen),
    .fifo_rxd  (fifo_rxd),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .err       (err)
  );

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Byte accepted from a per-cycle sample list and the cycles it takes:
  // filtered build -> first window of STABLE_CNT equal samples; else first sample.
  function automatic void resolve(input byte_q_t s, output logic [7:0] b, output int dwell);
`ifdef INTAN_RX_STABLE_EN
    b     = s[s.size()-1];
    dwell = s.size();
    for (int k = STABLE_CNT - 1; k < s.size(); k++) begin
      bit same = 1'b1;
      for (int j = k - STABLE_CNT + 1; j <= k; j++)
        if (s[j] != s[k]) same = 1'b0;
      if (same) begin
        b     = s[k];
        dwell = k + 1;
        return;
      end
    end
`else
    b     = s[0];
    dwell = 1;
`endif
  endfunction

  // Noisy prefix over two values followed by a guaranteed stable run
  function automatic void gen_seq(output byte_q_t s);
    logic [7:0] a = 8'($urandom);
    logic [7:0] c = 8'($urandom);
    int n = $urandom_range(0, 8);
    s = {};
    for (int i = 0; i < n; i++) s.push_back(($urandom_range(0, 1) == 1) ? a : c);
    for (int i = 0; i < STABLE_CNT; i++) s.push_back(a);
  endfunction

  task automatic read_byte(input string tag, input logic [1:0] sel, input byte_q_t s,
                           output logic [7:0] b);
    int dwell;
    resolve(s, b, dwell);
    for (int i = 0; i < dwell; i++) begin
      chk16({tag, " rxen"}, {14'b0, fifo_rxen}, {14'b0, sel});
      chk1({tag, " valid_low"}, dout_valid, 1'b0);
      fs_read  = 1'($urandom_range(0, 1));
      fifo_rxd = (sel == 2'b10) ? {s[i], 8'($urandom)} : {8'($urandom), s[i]};
      step();
    end
  endtask

  // Full transfer from IDLE; stall < 0 picks a random SEND stall
  task automatic transfer(input string tag, input int wait_cyc, input int stall_arg,
                          input bit use_fix, input byte_q_t hfix, input byte_q_t lfix);
    byte_q_t     hs, ls;
    logic [7:0]  hb, lb;
    logic [15:0] word;
    int          stall;
    fs_read = 1'b1; fifo_full = 1'b0; step();
    fs_read = 1'b0;
    chk1({tag, " err_cleared"}, err, 1'b0);
    for (int i = 0; i < wait_cyc; i++) begin
      chk16({tag, " wait_rxen"}, {14'b0, fifo_rxen}, 16'h0);
      chk1({tag, " wait_fd"}, fd_read, 1'b0);
      fs_read = 1'($urandom_range(0, 1));
      step();
    end
    fifo_full = 1'b1;
    chk16({tag, " wait_rxen"}, {14'b0, fifo_rxen}, 16'h0);
    step();
    word = 16'h0;
    for (int w = 0; w < WORD_NUM; w++) begin
      if (use_fix) begin hs = hfix; ls = lfix; end
      else begin gen_seq(hs); gen_seq(ls); end
      read_byte({tag, " hi"}, 2'b10, hs, hb);
      read_byte({tag, " lo"}, 2'b01, ls, lb);
      word  = {hb, lb};
      stall = (stall_arg < 0) ? $urandom_range(0, 6) : stall_arg;
      dout_ready = 1'b0;
      for (int i = 0; i < stall; i++) begin
        chk1({tag, " stall_valid"}, dout_valid, 1'b1);
        chk16({tag, " stall_dout"}, dout, word);
        chk16({tag, " stall_rxen"}, {14'b0, fifo_rxen}, 16'h0);
        chk1({tag, " stall_err"}, err, 1'b0);
        fs_read = 1'($urandom_range(0, 1));
        step();
      end
      chk1({tag, " send_valid"}, dout_valid, 1'b1);
      chk16({tag, " send_dout"}, dout, word);
      fs_read = 1'($urandom_range(0, 1));
      dout_ready = 1'b1; step();
      dout_ready = 1'b0;
      chk1({tag, " valid_drop"}, dout_valid, 1'b0);
      chk16({tag, " dout_hold"}, dout, word);
    end
    chk1({tag, " done_fd"}, fd_read, 1'b1);
    chk1({tag, " done_err"}, err, 1'b0);
    fs_read = 1'b0; fifo_full = 1'b0; step();
    chk1({tag, " idle_fd"}, fd_read, 1'b0);
    chk16({tag, " idle_dout"}, dout, word);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk1({tag, " fd_read"}, fd_read, 1'b0);
    chk16({tag, " rxen"}, {14'b0, fifo_rxen}, 16'h0);
    chk16({tag, " dout"}, dout, 16'h0);
    chk1({tag, " valid"}, dout_valid, 1'b0);
    chk1({tag, " err"}, err, 1'b0);
  endtask

  initial begin
    byte_q_t    hq, lq, empty_q;
    logic [7:0] junk;
    empty_q = {};
    rst = 1'b1; fs_read = 1'b0; fifo_full = 1'b0; fifo_rxd = 16'h0; dout_ready = 1'b0;
    step(); step();
    check_reset_outputs("reset");
    rst = 1'b0;
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk16("idle_no_start rxen", {14'b0, fifo_rxen}, 16'h0);
    end
    fifo_full = 1'b0;

    // Constant A55A, immediate handshake
    hq = '{8'hA5, 8'hA5, 8'hA5, 8'hA5}; lq = '{8'h5A, 8'h5A, 8'h5A, 8'h5A};
    transfer("a55a", 0, 0, 1'b1, hq, lq);

    // High byte settles after a glitch
    hq = '{8'h12, 8'h12, 8'h34, 8'h34, 8'h34}; lq = '{8'h56, 8'h56, 8'h56};
    transfer("glitch", 2, 0, 1'b1, hq, lq);

    // 1234 with single-cycle expectations when unfiltered
    hq = '{8'h12, 8'h12, 8'h12}; lq = '{8'h34, 8'h34, 8'h34};
    transfer("w1234", 1, 0, 1'b1, hq, lq);

    // Ten-cycle downstream stall
    transfer("stall10", 3, 10, 1'b0, empty_q, empty_q);

    // WAIT timeout
    fs_read = 1'b1; fifo_full = 1'b0; step();
    fs_read = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      chk1("wto fd_low", fd_read, 1'b0);
      chk1("wto err_low", err, 1'b0);
      chk1("wto valid_low", dout_valid, 1'b0);
      step();
    end
    chk1("wto done_fd", fd_read, 1'b1);
    chk1("wto done_err", err, 1'b1);
    chk1("wto done_valid", dout_valid, 1'b0);
    step();
    chk1("wto idle_fd", fd_read, 1'b0);
    chk1("wto err_sticky", err, 1'b1);
    step();
    chk1("wto err_sticky2", err, 1'b1);
    transfer("after_wto", 4, -1, 1'b0, empty_q, empty_q);

`ifdef INTAN_RX_STABLE_EN
    // RDH timeout with never-settling data
    fs_read = 1'b1; fifo_full = 1'b1; step();
    fs_read = 1'b0; step();
    for (int i = 0; i < TIMEOUT; i++) begin
      chk16("rto rxen", {14'b0, fifo_rxen}, 16'h2);
      chk1("rto fd_low", fd_read, 1'b0);
      fifo_rxd = (i % 2 == 0) ? 16'h00FF : 16'hFF00;
      step();
    end
    chk1("rto done_fd", fd_read, 1'b1);
    chk1("rto done_err", err, 1'b1);
    chk1("rto done_valid", dout_valid, 1'b0);
    fifo_full = 1'b0; step();
    chk1("rto idle_fd", fd_read, 1'b0);
`endif

    // Asynchronous reset in the middle of RDL
    fs_read = 1'b1; fifo_full = 1'b1; step();
    fs_read = 1'b0; step();
    gen_seq(hq);
    read_byte("rst_mid hi", 2'b10, hq, junk);
    chk16("rst_mid in_rdl", {14'b0, fifo_rxen}, 16'h1);
    fifo_rxd = 16'h5555;
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_mid");
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk1("post_rst fd_low", fd_read, 1'b0);
      chk16("post_rst rxen", {14'b0, fifo_rxen}, 16'h0);
      chk1("post_rst valid", dout_valid, 1'b0);
      step();
    end
    fifo_full = 1'b0;

    // Randomized transfers
    for (int t = 0; t < 8; t++)
      transfer("rand", $urandom_range(0, TIMEOUT - 2), -1, 1'b0, empty_q, empty_q);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
